// File: rtl/lut_load_ctrl.sv
// ---------------------------------------------------------------------------
// lut_load_ctrl
//
// Load sequencer for the four-direction LUT bank (eight dual-port SRAMs that
// are written together). Incoming 32-bit LUT words are packed into even/odd
// pairs and broadcast as one write per pair on data1/data2 and addr1/addr2,
// with LUT_WE pulsed low once per pair. When the last pair has been written,
// SR_start hands the SRAM address ports over to the SR datapath.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is registered and is 1 only while loading.
// in_data is ignored whenever in_valid is 0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle pulse; begins a load (honoured in IDLE/RUN)
//   sr_stop            one-cycle pulse; leaves RUN for IDLE
//   in_valid/in_ready  word handshake, in_data = LUT word (index order)
//   data1/data2        even/odd word of the current pair
//   addr1/addr2        ADDR_OFFSET + 2k / ADDR_OFFSET + 2k + 1 (mod 2^ADDR_W)
//   LUT_WE             SRAM write enable, active-low
//   SR_start           LUT owned by the SR datapath
//   load_done          one-cycle pulse as SR_start rises
//   word_cnt           words accepted in the current load (saturates)
//   checksum           wrapping sum of accepted words
//   state_dbg          current FSM state (debug observation)
//
// Build option: define LUT_CHECKSUM_EN to enable the checksum accumulator;
// otherwise checksum is tied to zero.
// ---------------------------------------------------------------------------
module lut_load_ctrl #(
  parameter int DEPTH       = 3392,
  parameter int ADDR_W      = 12,
  parameter int ADDR_OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sr_stop,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [31:0]       data1,
  output logic [31:0]       data2,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              LUT_WE,
  output logic              SR_start,
  output logic              load_done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [31:0]       checksum,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_OFFSET);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic [31:0]       hold_q, hold_d;     // even word waiting for its partner
  logic              pend_q, pend_d;     // pair data presented, write due next edge
  logic [ADDR_W-1:0] pair_q, pair_d;     // index k of the next pair to write
  logic              in_ready_d, lut_we_d, sr_start_d, load_done_d;
  logic [31:0]       data1_d, data2_d;
  logic [ADDR_W-1:0] addr1_d, addr2_d, word_cnt_d;
  logic              load_begin;
  logic              xfer;

  assign xfer      = in_valid && in_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pend_d      = 1'b0;
    pair_d      = pair_q;
    in_ready_d  = in_ready;
    data1_d     = data1;
    data2_d     = data2;
    addr1_d     = addr1;
    addr2_d     = addr2;
    lut_we_d    = 1'b1;
    sr_start_d  = SR_start;
    load_done_d = 1'b0;
    word_cnt_d  = word_cnt;
    load_begin  = 1'b0;

    // The LUT captures data one cycle before addresses, so the address
    // update and the write strobe trail the data update by one edge.
    if (pend_q) begin
      addr1_d  = BASE + {pair_q[ADDR_W-2:0], 1'b0};
      addr2_d  = addr1_d + ADDR_W'(1);
      lut_we_d = 1'b0;
      pair_d   = pair_q + ADDR_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_begin = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (word_cnt != FULL) begin
            word_cnt_d = word_cnt + ADDR_W'(1);
          end
          // word_cnt[0] is the pair phase: even index latches, odd completes.
          if (!word_cnt[0]) begin
            hold_d = in_data;
          end else begin
            data1_d = hold_q;
            data2_d = in_data;
            pend_d  = 1'b1;
          end
          if (word_cnt == LAST) begin
            state_d    = S_FLUSH;
            in_ready_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        // LUT_WE low here means the final write completes on this edge.
        if (!LUT_WE) begin
          state_d     = S_RUN;
          sr_start_d  = 1'b1;
          load_done_d = 1'b1;
        end
      end
      S_RUN: begin
        if (sr_stop) begin
          state_d    = S_IDLE;
          sr_start_d = 1'b0;
        end else if (start) begin
          load_begin = 1'b1;
          sr_start_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_begin) begin
      state_d    = S_LOAD;
      in_ready_d = 1'b1;
      word_cnt_d = '0;
      pair_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      pair_q    <= '0;
      in_ready  <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      addr1     <= BASE;
      addr2     <= BASE + ADDR_W'(1);
      LUT_WE    <= 1'b1;
      SR_start  <= 1'b0;
      load_done <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      pair_q    <= pair_d;
      in_ready  <= in_ready_d;
      data1     <= data1_d;
      data2     <= data2_d;
      addr1     <= addr1_d;
      addr2     <= addr2_d;
      LUT_WE    <= lut_we_d;
      SR_start  <= sr_start_d;
      load_done <= load_done_d;
      word_cnt  <= word_cnt_d;
    end
  end

`ifdef LUT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (load_begin) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_lut_load_ctrl.sv
module tb_lut_load_ctrl;

  localparam int DEPTH       = 8;
  localparam int ADDR_W      = 12;
  localparam int ADDR_OFFSET = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, sr_stop, in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [31:0]       data1, data2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic              LUT_WE, SR_start, load_done;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       checksum;
  logic [1:0]        state_dbg;

  lut_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ADDR_OFFSET(ADDR_OFFSET)) dut (
    .clk(clk), .rst(rst), .start(start), .sr_stop(sr_stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data1(data1), .data2(data2), .addr1(addr1), .addr2(addr2),
    .LUT_WE(LUT_WE), .SR_start(SR_start), .load_done(load_done),
    .word_cnt(word_cnt), .checksum(checksum), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [31:0]       d1;
    logic [31:0]       d2;
  } wr_t;

  wr_t         exp_wr_q[$];    // expected SRAM pair writes in order
  logic [63:0] exp_done_q[$];  // {word_cnt, checksum} expected at load_done
  logic [31:0] words [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: n_words accepted -> floor(n/2) pair writes at
  // OFFSET+2k / OFFSET+2k+1; a complete load also yields one load_done.
  task automatic expect_load(input int n_words);
    logic [31:0] sum;
    wr_t e;
    sum = 32'h0;
    for (int k = 0; k < n_words / 2; k++) begin
      e.a1 = ADDR_W'((ADDR_OFFSET + 2 * k) % (1 << ADDR_W));
      e.a2 = ADDR_W'((ADDR_OFFSET + 2 * k + 1) % (1 << ADDR_W));
      e.d1 = words[2 * k];
      e.d2 = words[2 * k + 1];
      exp_wr_q.push_back(e);
    end
    for (int i = 0; i < n_words; i++) sum = sum + words[i];
`ifndef LUT_CHECKSUM_EN
    sum = 32'h0;
`endif
    if (n_words == DEPTH) exp_done_q.push_back({32'(DEPTH), sum});
  endtask

  // ---------------- monitor ----------------
  logic        prev_we = 1'b1;
  logic        prev_done = 1'b0;
  logic [31:0] prev_d1 = '0, prev_d2 = '0;

  always @(negedge clk) begin
    wr_t         e;
    logic [63:0] d;
    if (!rst) begin
      if (LUT_WE === 1'b0) begin
        check("we_single_cycle", {63'b0, prev_we}, 64'd1);
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr1=0x%0h addr2=0x%0h, expected no write", addr1, addr2);
        end else begin
          e = exp_wr_q.pop_front();
          check("addr1", {52'b0, addr1}, {52'b0, e.a1});
          check("addr2", {52'b0, addr2}, {52'b0, e.a2});
          check("data1", {32'b0, data1}, {32'b0, e.d1});
          check("data2", {32'b0, data2}, {32'b0, e.d2});
          check("data1_early", {32'b0, prev_d1}, {32'b0, e.d1});
          check("data2_early", {32'b0, prev_d2}, {32'b0, e.d2});
        end
      end
      if (load_done === 1'b1) begin
        check("done_single_cycle", {63'b0, prev_done}, 64'd0);
        n_checks++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_load_done: word_cnt=%0d, expected no pulse", word_cnt);
        end else begin
          d = exp_done_q.pop_front();
          check("done_sr_start", {63'b0, SR_start}, 64'd1);
          check("done_word_cnt", {52'b0, word_cnt}, {32'b0, d[63:32]});
          check("done_checksum", {32'b0, checksum}, {32'b0, d[31:0]});
        end
      end
    end
    prev_we   = rst ? 1'b1 : LUT_WE;
    prev_done = rst ? 1'b0 : load_done;
    prev_d1   = data1;
    prev_d2   = data2;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    sr_stop = 1'b1;
    tick();
    sr_stop = 1'b0;
  endtask

  // gap_mode: 0 = valid held high, 1 = one idle cycle after each word,
  // 2 = random 0..2 idle cycles
  task automatic feed(input int from, input int to, input int gap_mode);
    logic accepted;
    int   waited, gaps;
    for (int i = from; i < to; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      accepted = 1'b0;
      waited   = 0;
      while (!accepted && waited < 40) begin
        @(negedge clk);
        accepted = in_ready;
        tick();
        waited++;
      end
      check("word_accepted", {63'b0, accepted}, 64'd1);
      in_valid = 1'b0;
      in_data  = $urandom;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) tick();
    end
  endtask

  task automatic wait_run();
    int waited;
    waited = 0;
    while (SR_start !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reach_run", {63'b0, SR_start}, 64'd1);
    check("run_in_ready", {63'b0, in_ready}, 64'd0);
    check("run_word_cnt", {52'b0, word_cnt}, 64'(DEPTH));
    tick();
    check("run_lut_we", {63'b0, LUT_WE}, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd0);
    check({tag, "_data1"}, {32'b0, data1}, 64'd0);
    check({tag, "_data2"}, {32'b0, data2}, 64'd0);
    check({tag, "_addr1"}, {52'b0, addr1}, 64'(ADDR_OFFSET));
    check({tag, "_addr2"}, {52'b0, addr2}, 64'(ADDR_OFFSET + 1));
    check({tag, "_lut_we"}, {63'b0, LUT_WE}, 64'd1);
    check({tag, "_sr_start"}, {63'b0, SR_start}, 64'd0);
    check({tag, "_load_done"}, {63'b0, load_done}, 64'd0);
    check({tag, "_word_cnt"}, {52'b0, word_cnt}, 64'd0);
    check({tag, "_checksum"}, {32'b0, checksum}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; sr_stop = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Load 0x10..0x17 with valid held high
    for (int i = 0; i < DEPTH; i++) words[i] = 32'h10 + 32'(i);
    expect_load(DEPTH);
    pulse_start();
    feed(0, DEPTH, 0);
    wait_run();

    // sr_stop returns to IDLE; in_ready stays low
    pulse_stop();
    check("stop_sr_start", {63'b0, SR_start}, 64'd0);
    check("stop_in_ready", {63'b0, in_ready}, 64'd0);
    repeat (3) tick();
    check("idle_in_ready", {63'b0, in_ready}, 64'd0);

    // Same load with in_valid toggling
    expect_load(DEPTH);
    pulse_start();
    feed(0, DEPTH, 1);
    wait_run();

    // Restart from RUN; a start during LOAD is ignored
    for (int i = 0; i < DEPTH; i++) words[i] = 32'h20 + 32'(i);
    expect_load(DEPTH);
    pulse_start();
    check("restart_sr_start", {63'b0, SR_start}, 64'd0);
    check("restart_in_ready", {63'b0, in_ready}, 64'd1);
    check("restart_word_cnt", {52'b0, word_cnt}, 64'd0);
    feed(0, 3, 0);
    pulse_start();
    check("ignored_start_word_cnt", {52'b0, word_cnt}, 64'd3);
    check("ignored_start_in_ready", {63'b0, in_ready}, 64'd1);
    feed(3, DEPTH, 2);
    wait_run();
    pulse_stop();

    // Reset after five words: two pairs written, rest discarded
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    expect_load(5);
    pulse_start();
    feed(0, 5, 0);
    repeat (3) tick();
    check("partial_writes_done", 64'(exp_wr_q.size()), 64'd0);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    rst = 1'b0;
    tick();

    // Checksum wrap: 0xFFFFFFFF x2 + 0x1 x6
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'hFFFF_FFFF;
    for (int i = 2; i < DEPTH; i++) words[i] = 32'h1;
    expect_load(DEPTH);
    pulse_start();
    check("reload_word_cnt", {52'b0, word_cnt}, 64'd0);
    feed(0, DEPTH, 2);
    wait_run();
`ifdef LUT_CHECKSUM_EN
    check("checksum_wrap", {32'b0, checksum}, 64'h4);
`else
    check("checksum_tied", {32'b0, checksum}, 64'h0);
`endif

    // Randomized loads, alternately restarting from RUN or via IDLE
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        pulse_stop();
        repeat ($urandom_range(0, 3)) tick();
      end
      expect_load(DEPTH);
      pulse_start();
      feed(0, DEPTH, 2);
      wait_run();
    end

    repeat (5) tick();
    check("writes_drained", 64'(exp_wr_q.size()), 64'd0);
    check("done_drained", 64'(exp_done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_load_ctrl.md
Name: lut_load_ctrl

Overview:
Sequencer for the 3392x32 four-direction LUT bank. It accepts a stream of 32-bit LUT words over a valid/ready handshake and packs them into pairs. It drives data1/data2, addr1/addr2 and LUT_WE to broadcast-write all eight dual-port SRAMs. When loading completes it raises SR_start, which hands the SRAM address ports to the SR datapath.

Parameters:
DEPTH, 3392, LUT words to load; must be even.
ADDR_W, 12, width of LUT address outputs.
ADDR_OFFSET, 4, added to every SRAM word index; the LUT subtracts 4 internally.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
start  in  1  one-cycle pulse that begins a load.
sr_stop  in  1  one-cycle pulse that ends the SR phase and returns to IDLE.
in_valid  in  1  input word valid.
in_data  in  32  LUT word; words arrive in index order 0..DEPTH-1.
in_ready  out  1  controller accepts a word this cycle.
data1  out  32  even word of the current pair, to LUT data1.
data2  out  32  odd word of the current pair, to LUT data2.
addr1  out  ADDR_W  ADDR_OFFSET + 2k.
addr2  out  ADDR_W  ADDR_OFFSET + 2k+1.
LUT_WE  out  1  SRAM write enable, active-low (0 = write).
SR_start  out  1  LUT owned by the SR datapath.
load_done  out  1  one-cycle pulse when SR_start rises.
word_cnt  out  ADDR_W  words accepted in the current load.
checksum  out  32  see Optional Feature.

Behaviour:
- Reset values: in_ready=0, data1=data2=0, addr1=ADDR_OFFSET, addr2=ADDR_OFFSET+1, LUT_WE=1, SR_start=0, load_done=0, word_cnt=0, checksum=0. Reset is asynchronous. A reset mid-load discards the partial load; already-written SRAM contents are not restored.
- All outputs are registered.
- A transfer occurs on a clock edge where in_valid and in_ready are both 1.
- FSM states:
  - IDLE: in_ready=0. On start, go to LOAD and clear word_cnt and the pair phase.
  - LOAD: in_ready=1.
    - Even-indexed word: latched internally.
    - Odd-indexed word: at the same edge E, data1 takes the latched word and data2 takes in_data.
    - At edge E+1: addr1/addr2 take their values for pair k, and LUT_WE=0 for exactly one cycle. The LUT registers its data one cycle before its addresses, so the data/address skew of one cycle is mandatory.
    - When the last word (index DEPTH-1) is accepted, go to FLUSH; in_ready drops in the cycle after that acceptance.
  - FLUSH: wait until the final LUT_WE=0 cycle has completed (SRAM write at E+2), then go to RUN.
  - RUN: SR_start=1 and load_done=1 for the first cycle; in_ready=0; LUT_WE=1.
    - On sr_stop: SR_start=0 and go to IDLE.
    - On start: SR_start=0 and go to LOAD, restarting from word 0.
- start or sr_stop in any other state is ignored.
- Back-to-back pairs at one word per cycle: pairs are at least 2 cycles apart, so LUT_WE pulses never overlap and data1/data2 stay stable for the SRAM sampling edge.
- in_valid gaps stall with no write; addr1/addr2 and data1/data2 hold.
- word_cnt increments per transfer and saturates at DEPTH.
- addr1/addr2 hold their last values in RUN (the LUT ignores them while SR_start=1).
- Addresses are computed modulo 2^ADDR_W.

Optional Feature:
LUT_CHECKSUM_EN.
- Defined: checksum is a 32-bit wrapping sum of every accepted in_data. It clears on start and is stable from load_done onward.
- Undefined: checksum is tied to 0 and no adder is synthesised.

Test Plan:
- DEPTH=8, start, then words 0x10..0x17 with valid held high -> four LUT_WE=0 pulses with addr1/addr2 = 4/5, 6/7, 8/9, 10/11. data1/data2 = 0x10/0x11 … 0x16/0x17, each valid one cycle before its pulse. load_done pulses once; SR_start=1; word_cnt=8.
- Same load with in_valid toggling 1,0,1,0 -> identical address/data pairs. No LUT_WE pulse occurs while a pair is incomplete.
- Reset asserted after 5 words -> all outputs return to reset values asynchronously. A following start reloads from addr1=4 with word_cnt=0.
- In RUN, pulse start -> SR_start falls next cycle and in_ready=1. A new load of 0x20..0x27 completes with a second load_done.
- In RUN, pulse sr_stop -> SR_start=0 and in_ready stays 0. A start pulse in LOAD is ignored (no counter reset).
- With LUT_CHECKSUM_EN, words 0xFFFFFFFF×2 and 0x1×6 -> checksum=0x00000004 (wrapped). Without the macro, checksum=0.
